// File: rtl/fetch_predict_stage.sv
// Instruction-fetch stage: PC register, static branch/jump prediction,
// return-address stack for jr $ra, and the IF/ID pipeline register.
module fetch_predict_stage #(
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic [31:0] startPC,
   input  logic [31:0] Instruction,
   input  logic        Stall,
   input  logic        Redirect,
   input  logic [31:0] RedirectPC,
   output logic [31:0] PC,
   output logic [31:0] IFID_Instr,
   output logic [31:0] IFID_PCPlus4,
   output logic        IFID_PredTaken,
   output logic [31:0] IFID_PredTarget,
   output logic        IFID_Valid
);

   localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] FN_JR      = 6'h08;
   localparam logic [4:0] REG_RA     = 5'd31;

   logic [31:0]      ras [RAS_DEPTH];
   logic [PTR_W-1:0] ras_ptr;    // next slot to write; top of stack is ras_ptr-1
   logic [CNT_W-1:0] ras_count;

   logic [5:0]  op;
   logic [5:0]  funct;
   logic [4:0]  rs;
   logic [31:0] pc_plus4;
   logic [31:0] br_offset;
   logic [31:0] br_target;
   logic [31:0] jump_target;
   logic [31:0] ras_top;
   logic [31:0] next_pc;
   logic        pred_taken;
   logic        do_push;
   logic        do_pop;
   logic        advance;

   assign op          = Instruction[31:26];
   assign funct       = Instruction[5:0];
   assign rs          = Instruction[25:21];
   assign pc_plus4    = PC + 32'd4;
   assign br_offset   = {{14{Instruction[15]}}, Instruction[15:0], 2'b00};
   assign br_target   = pc_plus4 + br_offset;
   assign jump_target = {pc_plus4[31:28], Instruction[25:0], 2'b00};
   assign ras_top     = ras[ras_ptr - PTR_W'(1)];
   assign advance     = !Redirect && !Stall;

   // Static prediction: next fetch address and RAS push/pop requests
   always_comb begin
      next_pc    = pc_plus4;
      pred_taken = 1'b0;
      do_push    = 1'b0;
      do_pop     = 1'b0;
      case (op)
         OP_J: begin
            pred_taken = 1'b1;
            next_pc    = jump_target;
         end
         OP_JAL: begin
            pred_taken = 1'b1;
            next_pc    = jump_target;
            do_push    = 1'b1;
         end
         OP_BEQ, OP_BNE: begin
            // backward (negative offset) predicted taken
            if (Instruction[15]) begin
               pred_taken = 1'b1;
               next_pc    = br_target;
            end
         end
         OP_SPECIAL: begin
            if (funct == FN_JR && rs == REG_RA && ras_count != '0) begin
               pred_taken = 1'b1;
               next_pc    = ras_top;
               do_pop     = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // PC and IF/ID register: reset > redirect flush > stall hold > advance
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         PC              <= startPC;
         IFID_Instr      <= '0;
         IFID_PCPlus4    <= '0;
         IFID_PredTaken  <= 1'b0;
         IFID_PredTarget <= '0;
         IFID_Valid      <= 1'b0;
      end else if (Redirect) begin
         PC              <= RedirectPC;
         IFID_Instr      <= '0;
         IFID_PCPlus4    <= '0;
         IFID_PredTaken  <= 1'b0;
         IFID_PredTarget <= '0;
         IFID_Valid      <= 1'b0;
      end else if (!Stall) begin
         PC              <= next_pc;
         IFID_Instr      <= Instruction;
         IFID_PCPlus4    <= pc_plus4;
         IFID_PredTaken  <= pred_taken;
         IFID_PredTarget <= next_pc;
         IFID_Valid      <= 1'b1;
      end
   end

   // Circular return-address stack; a push when full overwrites the oldest entry
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         ras_ptr   <= '0;
         ras_count <= '0;
         for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
            ras[PTR_W'(i)] <= '0;
         end
      end else if (advance) begin
         if (do_push) begin
            ras[ras_ptr] <= pc_plus4;
            ras_ptr      <= ras_ptr + PTR_W'(1);
            if (ras_count != CNT_W'(RAS_DEPTH)) begin
               ras_count <= ras_count + CNT_W'(1);
            end
         end else if (do_pop) begin
            ras_ptr   <= ras_ptr - PTR_W'(1);
            ras_count <= ras_count - CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_fetch_predict_stage.sv
// Self-checking bench for fetch_predict_stage: directed scenarios plus a
// randomized run compared against a queue-based behavioural model.
module tb_fetch_predict_stage;

   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] JR_RA = 32'h03E0_0008;

   logic        CLK = 1'b0;
   logic        Reset;
   logic [31:0] startPC;
   logic [31:0] Instruction;
   logic        Stall;
   logic        Redirect;
   logic [31:0] RedirectPC;
   logic [31:0] PC;
   logic [31:0] IFID_Instr;
   logic [31:0] IFID_PCPlus4;
   logic        IFID_PredTaken;
   logic [31:0] IFID_PredTarget;
   logic        IFID_Valid;

   int checks = 0;
   int passed = 0;

   // behavioural model state
   logic [31:0] m_pc, m_instr, m_pc4, m_tgt;
   logic        m_taken, m_valid;
   logic [31:0] m_ras[$];

   fetch_predict_stage #(.RAS_DEPTH(DEPTH)) dut (
      .CLK(CLK), .Reset(Reset), .startPC(startPC), .Instruction(Instruction),
      .Stall(Stall), .Redirect(Redirect), .RedirectPC(RedirectPC), .PC(PC),
      .IFID_Instr(IFID_Instr), .IFID_PCPlus4(IFID_PCPlus4),
      .IFID_PredTaken(IFID_PredTaken), .IFID_PredTarget(IFID_PredTarget),
      .IFID_Valid(IFID_Valid)
   );

   always #5 CLK = ~CLK;

   // clear the model as a reset does
   task automatic model_reset(input logic [31:0] s);
      m_pc = s; m_instr = 0; m_pc4 = 0; m_tgt = 0; m_taken = 0; m_valid = 0;
      m_ras.delete();
   endtask

   // apply one clock: update model from the driven inputs, then wait past the edge
   task automatic tick();
      logic [31:0] pc4, nxt;
      logic signed [31:0] off;
      logic tk;
      logic [5:0] op;
      if (Redirect) begin
         m_pc = RedirectPC; m_instr = 0; m_pc4 = 0; m_tgt = 0; m_taken = 0; m_valid = 0;
      end else if (!Stall) begin
         pc4 = m_pc + 4;
         op  = Instruction[31:26];
         tk  = 0;
         nxt = pc4;
         if (op == 6'd2 || op == 6'd3) begin
            tk  = 1;
            nxt = (pc4 & 32'hF000_0000) + 32'(Instruction[25:0]) * 4;
            if (op == 6'd3) begin
               m_ras.push_back(pc4);
               if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end
         end else if ((op == 6'd4 || op == 6'd5) && Instruction[15]) begin
            off = $signed(Instruction[15:0]);
            tk  = 1;
            nxt = pc4 + 32'(off * 4);
         end else if (op == 6'd0 && Instruction[5:0] == 6'd8 &&
                      Instruction[25:21] == 5'd31 && m_ras.size() > 0) begin
            tk  = 1;
            nxt = m_ras.pop_back();
         end
         m_instr = Instruction; m_pc4 = pc4; m_taken = tk; m_tgt = nxt; m_valid = 1;
         m_pc = nxt;
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic go_to(input logic [31:0] a);
      Redirect = 1; RedirectPC = a;
      tick();
      Redirect = 0;
   endtask

   task automatic do_reset(input logic [31:0] s);
      Reset = 1; startPC = s; Stall = 0; Redirect = 0;
      @(posedge CLK); #1;
      model_reset(s);
      Reset = 0;
   endtask

   task automatic test_reset();
      Reset = 1; startPC = 32'h60; Instruction = 0; Stall = 0; Redirect = 0; RedirectPC = 0;
      repeat (2) @(posedge CLK);
      #1;
      checks++; if (PC !== 32'h60) $display("FAIL reset_pc: got %h want %h", PC, 32'h60); else passed++;
      checks++; if (IFID_Valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", IFID_Valid); else passed++;
      checks++; if (IFID_Instr !== 32'h0 || IFID_PredTarget !== 32'h0)
         $display("FAIL reset_ifid: got %h/%h want 0/0", IFID_Instr, IFID_PredTarget); else passed++;
      model_reset(32'h60);
      Reset = 0;
      tick();
      checks++; if (PC !== 32'h64) $display("FAIL seq_pc1: got %h want %h", PC, 32'h64); else passed++;
      checks++; if (IFID_Valid !== 1'b1 || IFID_PCPlus4 !== 32'h64 || IFID_PredTaken !== 1'b0)
         $display("FAIL seq_ifid1: got v=%b p4=%h t=%b want v=1 p4=64 t=0", IFID_Valid, IFID_PCPlus4, IFID_PredTaken);
      else passed++;
      tick();
      checks++; if (PC !== 32'h68) $display("FAIL seq_pc2: got %h want %h", PC, 32'h68); else passed++;
   endtask

   task automatic test_branches();
      go_to(32'h20);
      Instruction = 32'h1000_FFFC;
      tick();
      checks++; if (PC !== 32'h14 || IFID_PredTaken !== 1'b1 || IFID_PredTarget !== 32'h14)
         $display("FAIL beq_back: got pc=%h t=%b tgt=%h want 14/1/14", PC, IFID_PredTaken, IFID_PredTarget);
      else passed++;
      go_to(32'h20);
      Instruction = 32'h1400_0003;
      tick();
      checks++; if (PC !== 32'h24 || IFID_PredTaken !== 1'b0 || IFID_PredTarget !== 32'h24)
         $display("FAIL bne_fwd: got pc=%h t=%b tgt=%h want 24/0/24", PC, IFID_PredTaken, IFID_PredTarget);
      else passed++;
   endtask

   task automatic test_call_return();
      go_to(32'h180);
      Instruction = 32'h0C00_0070;
      tick();
      checks++; if (PC !== 32'h1C0 || IFID_PredTaken !== 1'b1)
         $display("FAIL jal: got pc=%h t=%b want 1c0/1", PC, IFID_PredTaken); else passed++;
      Instruction = 32'h0;
      tick();
      Instruction = JR_RA;
      tick();
      checks++; if (PC !== 32'h184 || IFID_PredTaken !== 1'b1 || IFID_PredTarget !== 32'h184)
         $display("FAIL jr_ret: got pc=%h t=%b tgt=%h want 184/1/184", PC, IFID_PredTaken, IFID_PredTarget);
      else passed++;
      tick();
      checks++; if (PC !== 32'h188 || IFID_PredTaken !== 1'b0)
         $display("FAIL jr_empty: got pc=%h t=%b want 188/0", PC, IFID_PredTaken); else passed++;
   endtask

   task automatic test_ras_overflow();
      logic [31:0] exp;
      go_to(32'h100);
      for (int i = 0; i < 5; i++) begin
         exp = 32'h200 + 32'h100 * i;
         Instruction = 32'h0C00_0000 | (exp >> 2);
         tick();
         checks++; if (PC !== exp) $display("FAIL nest_jal%0d: got %h want %h", i, PC, exp); else passed++;
      end
      Instruction = JR_RA;
      for (int k = 0; k < 5; k++) begin
         exp = (k < 4) ? 32'h504 - 32'h100 * k : 32'h208;
         tick();
         checks++; if (PC !== exp) $display("FAIL nest_jr%0d: got %h want %h", k, PC, exp); else passed++;
      end
   endtask

   task automatic test_stall_redirect();
      go_to(32'h3C);
      Instruction = 32'h2001_0005;
      tick();
      checks++; if (PC !== 32'h40) $display("FAIL pre_stall: got %h want %h", PC, 32'h40); else passed++;
      Stall = 1;
      Instruction = 32'h0800_0100;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (PC !== 32'h40 || IFID_Instr !== 32'h2001_0005 || IFID_PCPlus4 !== 32'h40 || IFID_Valid !== 1'b1)
            $display("FAIL stall%0d: got pc=%h i=%h p4=%h v=%b want 40/20010005/40/1",
                     i, PC, IFID_Instr, IFID_PCPlus4, IFID_Valid);
         else passed++;
      end
      Redirect = 1; RedirectPC = 32'h90;
      tick();
      checks++; if (PC !== 32'h90 || IFID_Valid !== 1'b0 || IFID_Instr !== 32'h0)
         $display("FAIL redirect: got pc=%h v=%b i=%h want 90/0/0", PC, IFID_Valid, IFID_Instr);
      else passed++;
      Stall = 0; Redirect = 0;
   endtask

   task automatic test_async_reset();
      go_to(32'h300);
      Instruction = 32'h0C00_0100;
      tick();
      startPC = 32'hA0;
      #2 Reset = 1;
      #1;
      checks++; if (PC !== 32'hA0 || IFID_Valid !== 1'b0 || IFID_Instr !== 32'h0)
         $display("FAIL async_rst: got pc=%h v=%b i=%h want a0/0/0", PC, IFID_Valid, IFID_Instr);
      else passed++;
      model_reset(32'hA0);
      @(posedge CLK); #1;
      Reset = 0;
      Instruction = JR_RA;
      tick();
      checks++; if (PC !== 32'hA4 || IFID_PredTaken !== 1'b0 || IFID_Valid !== 1'b1)
         $display("FAIL post_rst_jr: got pc=%h t=%b v=%b want a4/0/1", PC, IFID_PredTaken, IFID_Valid);
      else passed++;
   endtask

   task automatic test_random();
      logic [129:0] got, exp;
      do_reset($urandom & 32'hFFFF_FFFC);
      for (int n = 0; n < 600; n++) begin
         case ($urandom_range(0, 9))
            0:       Instruction = {6'h02, 26'($urandom)};
            1, 2:    Instruction = {6'h03, 26'($urandom)};
            3:       Instruction = {5'b00010, 1'($urandom), 10'($urandom), 16'($urandom)};
            4, 5:    Instruction = JR_RA;
            6:       Instruction = {6'h00, 5'($urandom), 15'h0, 6'h08};
            default: Instruction = $urandom;
         endcase
         Stall      = ($urandom_range(0, 99) < 15);
         Redirect   = ($urandom_range(0, 99) < 6);
         RedirectPC = $urandom & 32'hFFFF_FFFC;
         tick();
         got = {PC, IFID_Instr, IFID_PCPlus4, IFID_PredTaken, IFID_PredTarget, IFID_Valid};
         exp = {m_pc, m_instr, m_pc4, m_taken, m_tgt, m_valid};
         checks++;
         if (got !== exp) $display("FAIL rand%0d: got %h want %h", n, got, exp);
         else passed++;
      end
      Stall = 0; Redirect = 0;
   endtask

   initial begin
      test_reset();
      test_branches();
      test_call_return();
      test_ras_overflow();
      test_stall_redirect();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
